// File: rtl/receiver.sv
// 16x-oversampling UART receiver: 8N1 framing, glitch-filtered start detection, ready/ack handshake.
// Optional build macro RX_FRAME_ERR_EN adds a frame_err output and suppresses delivery of bytes with a low stop bit.
module receiver (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic       rdy,
    output logic [7:0] data
`ifdef RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    typedef enum logic [1:0] {HUNT, DATA, STOP, BREAK} state_t;

    state_t     state, state_nxt;
    logic       rx_meta, rx_s;
    logic [3:0] sample, sample_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       stop_eval;
    logic       load;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clken) begin
            case (state)
                HUNT:    if (!rx_s && sample == 4'd7)        state_nxt = DATA;
                DATA:    if (sample == 4'd15 && bit_idx == 3'd7) state_nxt = STOP;
                STOP:    if (sample == 4'd15)                state_nxt = rx_s ? HUNT : BREAK;
                BREAK:   if (rx_s)                           state_nxt = HUNT;
                default:                                     state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        sample_nxt  = sample;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        stop_eval   = 1'b0;
        if (clken) begin
            case (state)
                HUNT: begin
                    // Start must be low for 8 consecutive ticks; any high tick restarts the count.
                    if (rx_s || sample == 4'd7) sample_nxt = 4'd0;
                    else                        sample_nxt = sample + 4'd1;
                    if (!rx_s && sample == 4'd7) bit_idx_nxt = 3'd0;
                end
                DATA: begin
                    if (sample == 4'd15) begin
                        shreg_nxt[bit_idx] = rx_s;
                        sample_nxt         = 4'd0;
                        bit_idx_nxt        = bit_idx + 3'd1;
                    end else begin
                        sample_nxt = sample + 4'd1;
                    end
                end
                STOP: begin
                    if (sample == 4'd15) begin
                        stop_eval  = 1'b1;
                        sample_nxt = 4'd0;
                    end else begin
                        sample_nxt = sample + 4'd1;
                    end
                end
                BREAK: if (rx_s) sample_nxt = 4'd0;
                default: sample_nxt = 4'd0;
            endcase
        end
    end

`ifdef RX_FRAME_ERR_EN
    assign load = stop_eval && rx_s;
`else
    assign load = stop_eval;
`endif

    // Completion beats acknowledge on the same edge so a fresh byte is never lost.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sample  <= 4'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            data    <= 8'h00;
            rdy     <= 1'b0;
        end else begin
            sample  <= sample_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            if (load) data <= shreg;
            if (load)         rdy <= 1'b1;
            else if (rdy_clr) rdy <= 1'b0;
        end
    end

`ifdef RX_FRAME_ERR_EN
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)                   frame_err <= 1'b0;
        else if (stop_eval && rx_s)   frame_err <= 1'b0;
        else if (stop_eval)           frame_err <= 1'b1;
        else if (rdy_clr)             frame_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: exact-latency frame checks, glitch rejection, overrun, stop-bit error, mid-frame reset.
module tb_receiver;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       clken   = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rdy;
    logic [7:0] data;
`ifdef RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    receiver dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .rx      (rx),
        .clken   (clken),
        .rdy_clr (rdy_clr),
        .rdy     (rdy),
        .data    (data)
`ifdef RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #10 clk_50m = ~clk_50m;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clk_50m edge; clken fires on every 4th edge (edge index % 4 == 3).
    task automatic step();
        clken = ((cyc % 4) == 3);
        @(posedge clk_50m);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic v);
        rx      = v;
        rdy_clr = 1'b0;
        repeat (n) step();
    endtask

    task automatic clr_pulse();
        rdy_clr = 1'b1;
        step();
        rdy_clr = 1'b0;
    endtask

    // Start edge aligned to cyc%4==0: stop-bit evaluation lands on frame edge 607, 64 edges per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int n_edges,
                              input int clr_at, output logic r606, output logic r607);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        while ((cyc % 4) != 0) step();
        r606 = 1'b0;
        r607 = 1'b0;
        for (int j = 0; j < n_edges; j++) begin
            rx      = f[j / 64];
            rdy_clr = (j == clr_at);
            step();
            if (j == 606) r606 = rdy;
            if (j == 607) r607 = rdy;
        end
        rdy_clr = 1'b0;
        rx      = 1'b1;
    endtask

    logic r0, r1;

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_rdy",  8'(rdy), 8'd0);
        chk("reset_data", data,    8'h00);
`ifdef RX_FRAME_ERR_EN
        chk("reset_ferr", 8'(frame_err), 8'd0);
`endif
        rst_n = 1'b1;
        idle(20, 1'b1);

        // Basic frame with exact completion edge
        send_frame(8'h55, 1'b1, 640, -1, r0, r1);
        chk("f55_pre",  8'(r0), 8'd0);
        chk("f55_post", 8'(r1), 8'd1);
        chk("f55_data", data,   8'h55);
        idle(8, 1'b1);
        clr_pulse();
        chk("f55_clr",  8'(rdy), 8'd0);
        chk("f55_hold", data,    8'h55);
        clr_pulse();
        chk("clr_idle", 8'(rdy), 8'd0);

        // Start glitches: 4 ticks, then 7 ticks (one short of a start)
        while ((cyc % 4) != 0) step();
        idle(16, 1'b0);
        idle(100, 1'b1);
        chk("gl4_rdy",  8'(rdy), 8'd0);
        chk("gl4_data", data,    8'h55);
        while ((cyc % 4) != 0) step();
        idle(28, 1'b0);
        idle(40, 1'b1);
        chk("gl7_rdy",  8'(rdy), 8'd0);
        send_frame(8'h96, 1'b1, 640, -1, r0, r1);
        chk("f96_pre",  8'(r0), 8'd0);
        chk("f96_post", 8'(r1), 8'd1);
        chk("f96_data", data,   8'h96);
        clr_pulse();

        // Back-to-back overrun, then acknowledge colliding with completion
        send_frame(8'hA5, 1'b1, 640, -1, r0, r1);
        chk("fa5_post", 8'(r1), 8'd1);
        chk("fa5_data", data,   8'hA5);
        send_frame(8'h3C, 1'b1, 640, -1, r0, r1);
        chk("f3c_pre",  8'(r0), 8'd1);
        chk("f3c_post", 8'(r1), 8'd1);
        chk("f3c_data", data,   8'h3C);
        send_frame(8'hF0, 1'b1, 640, 607, r0, r1);
        chk("ff0_post", 8'(r1), 8'd1);
        chk("ff0_data", data,   8'hF0);
        clr_pulse();
        chk("ff0_clr",  8'(rdy), 8'd0);

        // Low stop bit, then line held low: receiver must wait in BREAK
        send_frame(8'h81, 1'b0, 640, -1, r0, r1);
        rx = 1'b0;
`ifdef RX_FRAME_ERR_EN
        chk("f81_ferr", 8'(frame_err), 8'd1);
        chk("f81_rdy",  8'(rdy),       8'd0);
        chk("f81_data", data,          8'hF0);
        clr_pulse();
        chk("f81_fclr", 8'(frame_err), 8'd0);
`else
        chk("f81_rdy",  8'(rdy), 8'd1);
        chk("f81_data", data,    8'h81);
        clr_pulse();
`endif
        idle(600, 1'b0);
        idle(100, 1'b1);
        chk("brk_rdy", 8'(rdy), 8'd0);
`ifdef RX_FRAME_ERR_EN
        chk("brk_data", data,          8'hF0);
        chk("brk_ferr", 8'(frame_err), 8'd0);
`else
        chk("brk_data", data, 8'h81);
`endif
        send_frame(8'h5A, 1'b1, 640, -1, r0, r1);
        chk("f5a_post", 8'(r1), 8'd1);
        chk("f5a_data", data,   8'h5A);
        clr_pulse();

        // Reset during data bit 3 of 0xC3, then a clean 0x18
        send_frame(8'hC3, 1'b1, 290, -1, r0, r1);
        rst_n = 1'b0;
        #1;
        chk("rst_rdy",  8'(rdy), 8'd0);
        chk("rst_data", data,    8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        idle(400, 1'b1);
        chk("abort_rdy",  8'(rdy), 8'd0);
        chk("abort_data", data,    8'h00);
        send_frame(8'h18, 1'b1, 640, -1, r0, r1);
        chk("f18_pre",  8'(r0), 8'd0);
        chk("f18_post", 8'(r1), 8'd1);
        chk("f18_data", data,   8'h18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have port clk_50m, input, 1: single system clock; all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port rx, input, 1: asynchronous serial line, idles high; frame is 1 start (low), 8 data LSB-first, 1 stop (high).
REQ-004 SHALL have port clken, input, 1: one-cycle enable pulse at 16x baud rate.
REQ-005 SHALL have port rdy_clr, input, 1: consumer acknowledge; clears rdy.
REQ-006 SHALL have port rdy, output, 1: a received byte is held on data.
REQ-007 SHALL have port data, output, 8: last received byte.
REQ-008 SHALL have port frame_err, output, 1, only when RX_FRAME_ERR_EN is defined: last frame had a low stop bit.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-010 SHALL implement states HUNT, DATA, STOP, BREAK with a 4-bit sample counter and a 3-bit bit index; none advance without clken=1.
REQ-011 HUNT: on clken with rx_s=1, sample<=0; with rx_s=0, sample<=sample+1; on clken with rx_s=0 and sample=7, go DATA with sample<=0 and bit index<=0.
REQ-012 HUNT SHALL reject start glitches: any high rx_s before the 8th consecutive low tick returns sample to 0 without leaving HUNT.
REQ-013 DATA: sample increments on each clken; on clken with sample=15 (bit centre), shift register[bit index]<=rx_s and sample<=0; after index 7, go STOP, else index+1.
REQ-014 STOP: sample increments on each clken; on clken with sample=15, evaluate rx_s and go HUNT if rx_s=1, else go BREAK.
REQ-015 BREAK SHALL stay until a clken with rx_s=1, then go HUNT with sample<=0.
REQ-016 On the STOP evaluation edge with rx_s=1, data<=shift register and rdy<=1 on that same clk_50m edge (zero extra latency).
REQ-017 rdy SHALL stay 1 until rdy_clr=1 is sampled; data SHALL be stable while rdy=1 unless a new frame completes.
REQ-018 Overrun: a frame completing while rdy=1 SHALL overwrite data, and rdy SHALL remain 1.
REQ-019 Simultaneous rdy_clr=1 and frame completion on the same edge: set wins, rdy=1, data=new byte.
REQ-020 rdy_clr while rdy=0 SHALL have no effect; rdy_clr SHALL not affect the state machine.
REQ-021 A clken pulse lasting more than one clk_50m cycle SHALL count once per cycle it is high; no edge detection is performed.

Reset
REQ-022 While rst_n=0: state=HUNT, sample=0, bit index=0, shift register=0x00, data=0x00, rdy=0, frame_err=0, both synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no rdy pulse; reception restarts from HUNT after release.

Configuration
REQ-024 Macro RX_FRAME_ERR_EN: defined means port frame_err exists; undefined means the port is absent.
REQ-025 With RX_FRAME_ERR_EN, a STOP evaluation with rx_s=0 SHALL set frame_err=1, leave data and rdy unchanged, and enter BREAK.
REQ-026 With RX_FRAME_ERR_EN, frame_err SHALL clear on rdy_clr=1 or on the next good frame completion.
REQ-027 Without RX_FRAME_ERR_EN, a STOP evaluation with rx_s=0 SHALL still load data and set rdy=1, then enter BREAK.

Verification
REQ-028 Drive frame 0x55 at 16 clken per bit, clken every 4 clocks -> rdy=1 with data=0x55 on the edge of the mid-stop evaluation; rdy_clr pulse -> rdy=0.
REQ-029 Drive rx low for 4 clken ticks, then high -> no state change past HUNT, rdy stays 0, data unchanged.
REQ-030 Drive back-to-back 0xA5 then 0x3C with no rdy_clr -> rdy=1 and data=0x3C; then rdy_clr asserted on the same edge as a third frame 0xF0 completes -> rdy=1 and data=0xF0.
REQ-031 Drive frame 0x81 with stop bit low -> with macro: frame_err=1, rdy=0, BREAK held until rx high; without macro: rdy=1, data=0x81.
REQ-032 Pulse rst_n low during data bit 3 of 0xC3, then send 0x18 -> outputs zero during reset, no rdy for the aborted frame, then rdy=1 with data=0x18.
